switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Sits directly downstream of the 10-bit switch synchronizer and consumes its synchronized SW vector.
- Filters mechanical bounce on the whole switch vector.
- Publishes a stable debounced copy plus one-cycle per-bit rise/fall and "changed" pulses for downstream mode/display logic.
- A new value is accepted only after it has been held unchanged for STABLE_CYCLES consecutive clocks.

Parameters:
- WIDTH, 10: number of switch bits.
- STABLE_CYCLES, 50000: consecutive stable clocks required before acceptance (1 ms at 50 MHz). Must be >= 1. Simulation uses 4.
- CNT_W, $clog2(STABLE_CYCLES+1): stability counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- SW_sync  in  WIDTH  synchronized switch vector (synchronizer SW_out).
- SW_db  out  WIDTH  debounced switch vector (registered).
- rise  out  WIDTH  one-cycle pulse per bit that went 0->1 in SW_db.
- fall  out  WIDTH  one-cycle pulse per bit that went 1->0 in SW_db.
- changed  out  1  one-cycle pulse whenever SW_db updates.
- busy  out  1  high while in SETTLING.

Behaviour:

Reset:
- reset_n low asynchronously clears cand, cnt, SW_db, rise, fall, changed and busy to 0, and forces state IDLE.
- Reset asserted mid-settling aborts the pending value; no pulse is emitted.

Internal state:
- cand (WIDTH): last sampled SW_sync.
- cnt (CNT_W).
- FSM with states IDLE and SETTLING.

Per rising edge (priority order):
1. SW_sync != cand: cand <= SW_sync; cnt <= 0; state <= SETTLING if SW_sync != SW_db, else IDLE.
2. Else, if state is SETTLING and cnt == STABLE_CYCLES-1 (commit):
   - SW_db <= cand
   - rise <= cand & ~SW_db
   - fall <= ~cand & SW_db
   - changed <= 1
   - cnt <= 0
   - state <= IDLE
3. Else, if state is SETTLING: cnt <= cnt+1.
4. Else (IDLE): cnt <= 0.

Pulses and busy:
- rise, fall and changed default to 0 every cycle, so they are exactly one cycle wide and coincide with the SW_db update.
- busy is a registered copy of (state == SETTLING).

Latency:
- Let edge k be the first edge that samples a new SW_sync value.
- If that value is held, SW_db and the pulses update at edge k+STABLE_CYCLES.
- With STABLE_CYCLES=1, the update happens on the next edge.

Boundary conditions:
- **Glitch back to SW_db before commit:** cand returns to the SW_db value and the state returns to IDLE; no pulses.
- **Any change during SETTLING:** restarts the count from 0 with the new cand.
- **SW_sync changes on the commit edge:** rule 1 takes priority, so the commit is suppressed and settling restarts on the new value. SW_db never takes a value that was not stable for the full window.
- **Counter bound:** cnt never exceeds STABLE_CYCLES-1; no wrap.
- **Multi-bit changes:** several bits changing together produce a single changed pulse with multiple rise/fall bits set.
- **X on SW_sync before the first drive:** treated as a change. The bench must drive SW_sync before reset release.

Test Plan (STABLE_CYCLES=4, 20 ns clock):
1. Reset:
   - Stimulus: hold reset_n=0 for 3 cycles with SW_sync=0, then release and hold for 10 cycles.
   - Required: SW_db=0, rise/fall/changed/busy stay 0.
2. Clean change:
   - Stimulus: SW_sync 0 -> 10'h0A5, held.
   - Required: busy=1 after edge k; SW_db=10'h0A5 at edge k+4; rise=10'h0A5, fall=0, changed=1 for exactly one cycle.
3. Glitch:
   - Stimulus: from SW_db=10'h0A5, SW_sync=10'h05A for 2 cycles, then back to 10'h0A5.
   - Required: SW_db stays 10'h0A5; no pulses; busy returns low.
4. Bounce then settle:
   - Stimulus: SW_sync 10'h05A, 10'h0A5, 10'h05A (1 cycle each), then 10'h05A held.
   - Required: commit 4 edges after the last change; SW_db=10'h05A, rise=10'h05A, fall=10'h0A5, one changed pulse.
5. Reset mid-settling:
   - Stimulus: start a 10'h0A5 -> 10'h05A change; pulse reset_n low at cnt=2; keep SW_sync=10'h05A.
   - Required: outputs go to 0 immediately; after release, SW_db=10'h05A 4 edges after the first sampling edge, with rise=10'h05A.
6. Change on commit edge:
   - Stimulus: SW_sync changes to 10'h3FF exactly on the edge where 10'h05A would commit.
   - Required: no commit of 10'h05A; SW_db=10'h3FF 4 edges later, with changed pulsed once.

Source files
------------

// File: rtl/switch_debouncer.sv
// Whole-vector switch debouncer: a new value commits STABLE_CYCLES edges after it is first sampled.
// No backpressure; rise/fall/changed are single-cycle pulses coincident with the SW_db update.
module switch_debouncer #(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] SW_sync,
  output logic [WIDTH-1:0] SW_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             busy
);

  typedef enum logic {IDLE, SETTLING} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sw_db_q, sw_db_d;
  logic [WIDTH-1:0]   rise_q, rise_d;
  logic [WIDTH-1:0]   fall_q, fall_d;
  logic               changed_q, changed_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    sw_db_d   = sw_db_q;
    rise_d    = '0;
    fall_d    = '0;
    changed_d = 1'b0;

    // A fresh sample always wins, even on what would have been the commit edge.
    if (SW_sync != cand_q) begin
      cand_d  = SW_sync;
      cnt_d   = '0;
      state_d = (SW_sync != sw_db_q) ? SETTLING : IDLE;
    end else if (state_q == SETTLING && cnt_q == CNT_LAST) begin
      sw_db_d   = cand_q;
      rise_d    = cand_q & ~sw_db_q;
      fall_d    = ~cand_q & sw_db_q;
      changed_d = 1'b1;
      cnt_d     = '0;
      state_d   = IDLE;
    end else if (state_q == SETTLING) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    busy_d = (state_d == SETTLING);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      sw_db_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      sw_db_q   <= sw_db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
    end
  end

  assign SW_db   = sw_db_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: the driver pushes per-edge expectations from a run-length model,
// and an independent monitor pops and compares one entry after every rising edge.
module tb_switch_debouncer;

  localparam int W = 10;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] SW_sync;
  logic [W-1:0] SW_db, rise, fall;
  logic         changed, busy;

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .SW_sync (SW_sync),
    .SW_db   (SW_db),
    .rise    (rise),
    .fall    (fall),
    .changed (changed),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
    logic         busy;
  } obs_t;

  obs_t exp_q[$];
  int   id_q[$];
  int   test_id = 0;
  int   checks  = 0;
  int   fails   = 0;

  // Reference model: a value commits on the (S+1)-th consecutive edge that samples it,
  // provided it differs from the current debounced value.
  logic [W-1:0] m_prev, m_db;
  int           m_run;

  task automatic model_reset();
    m_prev = '0;
    m_db   = '0;
    m_run  = 0;
  endtask

  task automatic drive(input logic [W-1:0] v);
    obs_t e;
    @(negedge clk);
    SW_sync = v;
    if (v != m_prev) m_run = 1;
    else if (m_run <= S) m_run = m_run + 1;
    m_prev    = v;
    e.rise    = '0;
    e.fall    = '0;
    e.changed = 1'b0;
    if (v != m_db && m_run == S + 1) begin
      e.rise    = v & ~m_db;
      e.fall    = ~v & m_db;
      e.changed = 1'b1;
      m_db      = v;
    end
    e.db   = m_db;
    e.busy = (v != m_db);
    exp_q.push_back(e);
    id_q.push_back(test_id);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (SW_db !== '0 || rise !== '0 || fall !== '0 || changed !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: got db=%h rise=%h fall=%h changed=%b busy=%b, expected all zero",
               name, SW_db, rise, fall, changed, busy);
    end
  endtask

  // Monitor: every rising edge presents one observable output word.
  initial begin
    obs_t e, a;
    int   id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        id = id_q.pop_front();
        a = {SW_db, rise, fall, changed, busy};
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL sb_test%0d @%0t: got db=%h rise=%h fall=%h changed=%b busy=%b, expected db=%h rise=%h fall=%h changed=%b busy=%b",
                   id, $time, a.db, a.rise, a.fall, a.changed, a.busy,
                   e.db, e.rise, e.fall, e.changed, e.busy);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    int           hold;

    // 1: reset with SW_sync driven low
    test_id = 1;
    SW_sync = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_hold");
    reset_n = 1'b1;
    repeat (10) drive('0);

    // 2: clean change
    test_id = 2;
    repeat (7) drive(10'h0A5);

    // 3: glitch that returns to the debounced value
    test_id = 3;
    repeat (2) drive(10'h05A);
    repeat (6) drive(10'h0A5);

    // 4: bounce then settle
    test_id = 4;
    drive(10'h05A);
    drive(10'h0A5);
    drive(10'h05A);
    repeat (6) drive(10'h05A);

    // 5: reset in the middle of settling
    test_id = 5;
    repeat (6) drive(10'h0A5);
    repeat (3) drive(10'h05A);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("reset_mid_settle");
    @(posedge clk);
    #2;
    check_zero("reset_mid_settle_held");
    reset_n = 1'b1;
    model_reset();
    repeat (7) drive(10'h05A);

    // 6: change exactly on the would-be commit edge
    test_id = 6;
    repeat (6) drive(10'h0A5);
    repeat (4) drive(10'h05A);
    repeat (7) drive(10'h3FF);

    // 7: randomized bouncing, including single-bit toggles of the debounced value
    test_id = 7;
    for (int n = 0; n < 70; n++) begin
      if ($urandom_range(0, 2) == 0) v = m_db ^ (W'(1) << $urandom_range(0, W - 1));
      else v = W'($urandom_range(0, (1 << W) - 1));
      hold = $urandom_range(1, 7);
      repeat (hold) drive(v);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d unchecked entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
